// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the CDC snapshot writer
package cdc_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE    = 1'b0;
  localparam state_t HOLDOFF = 1'b1;

  typedef logic [3:0] gap_t;

  localparam int WRITE_COUNT_W = 16;
  // Ring depth of the snapshot buffer; min_gap must keep writes well behind a lap.
  localparam int RING_DEPTH    = 32;

endpackage

// File: rtl/cdc_holdoff_timer.sv
// rtl/cdc_holdoff_timer.sv - loadable down-counter that flags expiry at zero
module cdc_holdoff_timer
  import cdc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  gap_t i_value,
  output logic o_expired
);

  gap_t r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/cdc_change_writer.sv
// rtl/cdc_change_writer.sv - change/force/refresh driven writer for the gray-pointer snapshot buffer
module cdc_change_writer
  import cdc_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int min_gap        = 4,
  parameter int refresh_period = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic [data_width-1:0]    i_value_in,
  input  logic                     i_force,
  output logic                     o_wr,
  output logic [data_width-1:0]    o_wr_data,
  output logic                     o_pending,
  output logic [WRITE_COUNT_W-1:0] o_write_count
);

  if (min_gap < 1 || min_gap > RING_DEPTH / 2) begin : g_bad_min_gap
    $error("cdc_change_writer: min_gap out of range 1..16");
  end

  localparam int RW = (refresh_period > 1) ? $clog2(refresh_period) : 1;
  localparam logic [RW-1:0] REFRESH_MAX = RW'((refresh_period > 0) ? refresh_period - 1 : 0);
  localparam bit HAS_REFRESH = (refresh_period > 0);
  localparam bit HAS_HOLDOFF = (min_gap > 1);
  // HOLDOFF lasts min_gap-1 cycles; the timer exits when it reads zero, hence min_gap-2.
  localparam gap_t GAP_LOAD = gap_t'((min_gap > 1) ? min_gap - 2 : 0);

  state_t                r_state;
  logic [data_width-1:0] r_last_written;
  logic                  r_initialised;
  logic                  r_pending_flag;
  logic [RW-1:0]         r_refresh_cnt;

  logic w_refresh_due;
  logic w_dirty;
  logic w_do_write;
  logic w_owed;
  logic w_gap_expired;

  assign w_refresh_due = HAS_REFRESH && (r_refresh_cnt == REFRESH_MAX);
  assign w_dirty       = !r_initialised || (i_value_in != r_last_written) || i_force
                         || w_refresh_due || r_pending_flag;
  assign w_do_write    = (r_state == IDLE) && i_enable && w_dirty;
  assign w_owed        = w_dirty && ((r_state == HOLDOFF) || !i_enable);

  cdc_holdoff_timer u_gap_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset_n),
    .i_load    (w_do_write && HAS_HOLDOFF),
    .i_value   (GAP_LOAD),
    .o_expired (w_gap_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_last_written <= '0;
      r_initialised  <= 1'b0;
      r_pending_flag <= 1'b0;
      r_refresh_cnt  <= '0;
      o_wr           <= 1'b0;
      o_wr_data      <= '0;
      o_pending      <= 1'b0;
      o_write_count  <= '0;
    end else begin
      o_wr <= w_do_write;
      if (w_do_write) begin
        o_wr_data      <= i_value_in;
        r_last_written <= i_value_in;
        r_initialised  <= 1'b1;
        r_pending_flag <= 1'b0;
        r_refresh_cnt  <= '0;
        o_pending      <= 1'b0;
        o_write_count  <= o_write_count + 1'b1;
        r_state        <= HAS_HOLDOFF ? HOLDOFF : IDLE;
      end else begin
        if (w_owed) begin
          r_pending_flag <= 1'b1;
        end
        o_pending <= r_pending_flag || w_owed;
        // Refresh counter saturates at its due value and holds while disabled.
        if (i_enable && !w_refresh_due) begin
          r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
        if ((r_state == HOLDOFF) && w_gap_expired) begin
          r_state <= IDLE;
        end
      end
    end
  end

endmodule
